nco_voice_scheduler: RTL and testbench
======================================

// Module: nco_voice_scheduler
// PURPOSE
//   Time-multiplexes one phase-accumulate + sine-lookup datapath across NUM_VOICES voices.
//   On each next_sample tick it sweeps all voices, one per clk:
//     - advances each voice's phase accumulator
//     - reads the shared sine table
//     - sums the enabled voices into one mixed sample
//   Sits between the audio sample-rate tick generator and the DAC/PWM path.
//   Replaces one standalone oscillator per voice.
// PARAMETERS
//   NUM_VOICES  4   voices swept per sample; power of 2, >=2
//   FCW_W       24  phase accumulator / frequency control word width
//   LUT_AW      8   sine table address width; address = phase[FCW_W-1 -: LUT_AW]
//   SAMPLE_W    14  signed sine table data width
//   MIX_W       SAMPLE_W+$clog2(NUM_VOICES)  mixed output width; sum can never overflow
// PORTS
//   clk          in   1          clock
//   rst          in   1          synchronous, active-high reset
//   cfg_we       in   1          config write strobe
//   cfg_voice    in   VW         voice index to write; VW = $clog2(NUM_VOICES)
//   cfg_fcw      in   FCW_W      new frequency control word
//   cfg_en       in   1          new voice enable
//   next_sample  in   1          1-cycle pulse: start a sweep
//   lut_addr     out  LUT_AW     sine table address, registered
//   lut_data     in   SAMPLE_W   signed sine table data; combinational from lut_addr
//   mix_out      out  MIX_W      signed mixed sample; held between updates
//   mix_valid    out  1          1-cycle pulse when mix_out updates
//   busy         out  1          high while a sweep is in progress
//   overrun      out  1          sticky flag; only with NCO_SCHED_OVERRUN_EN
// BEHAVIOUR
//   Reset
//     - all phase, fcw, en := 0
//     - mix_out, mix_valid, busy, lut_addr, overrun := 0
//     - state := IDLE
//   IDLE
//     - next_sample=1: state := FETCH, v := 0, acc := 0, busy := 1
//     - lut_addr := phase[0] top bits
//   FETCH (one cycle per voice v)
//     - lut_data corresponds to voice v's pre-update phase
//     - if en[v]:  acc += sign_ext(lut_data);  phase[v] += fcw[v]  (mod 2^FCW_W, natural wrap)
//     - if !en[v]: phase[v] held; acc unchanged
//     - lut_addr := address of voice v+1
//     - at v = NUM_VOICES-1: state := DONE
//   DONE
//     - mix_out := acc, mix_valid := 1, busy := 0
//     - state := IDLE
//   Timing
//     - latency: next_sample -> mix_valid = NUM_VOICES+1 cycles (4 voices: 5)
//     - next sweep may start the cycle after DONE
//   Config writes: accepted in any state, take effect the next cycle
//     - write to a voice already processed this sweep: applies next sweep
//     - write in the same cycle voice v is in FETCH: that update uses the old fcw/en
//     - cfg_en=0 also clears phase[v] to 0; cfg_en=1 keeps the current phase
//     - unchanged fcw/en rewritten: no effect
//   Boundary cases
//     - next_sample while busy (FETCH or DONE): ignored; sweep continues unaffected
//     - all voices disabled: mix_out = 0, mix_valid still pulses
//     - rst mid-sweep: immediate return to reset state; no mix_valid
// CONFIGURATION
//   NCO_SCHED_OVERRUN_EN defined
//     - overrun port exists
//     - set when next_sample arrives while busy=1; cleared only by rst
//   NCO_SCHED_OVERRUN_EN undefined
//     - no overrun port; dropped ticks are silent
// STRUCTURE
//   Shared audio package
//     - FCW_W, LUT_AW, SAMPLE_W defaults
//     - sched_state_t enum {IDLE, FETCH, DONE}
//   Sub-module nco_phase_bank
//     - per-voice fcw/en/phase register file
//     - one config write port, one read/update port indexed by v
//   Sine table stays external, shared through lut_addr/lut_data.
// TESTING
//   1. Reset, voice0 fcw=0x010000 en=1, others off; 3 ticks
//      -> lut_addr 0x00,0x01,0x02 at voice0 slots; mix_valid 5 cycles after each tick
//   2. All 4 voices fcw=0, en=1, table stub returns 8191
//      -> mix_out = 32764; busy high exactly 5 cycles
//   3. voice1 fcw=0xFFFFFF en=1, 2 ticks
//      -> phase1 0x000000 -> 0xFFFFFF -> 0xFFFFFE; lut_addr 0xFF on 2nd sweep (wrap)
//   4. next_sample again 2 cycles after a tick
//      -> ignored; one mix_valid only; overrun=1 (macro defined), stays 1 until rst
//   5. Write voice0 fcw=0x020000 during voice2 slot
//      -> current sweep uses old fcw; next sweep phase0 advances by 0x020000
//   6. Assert rst in voice1 slot
//      -> no mix_valid; all outputs 0 next cycle; next tick sweep starts from phase 0

Source files
------------

// File: rtl/nco_voice_scheduler_pkg.sv
// Shared audio definitions for the multi-voice NCO scheduler: default widths
// and the sweep state encoding.
package nco_voice_scheduler_pkg;

  localparam int NCO_NUM_VOICES = 4;
  localparam int NCO_FCW_W      = 24;
  localparam int NCO_LUT_AW     = 8;
  localparam int NCO_SAMPLE_W   = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/nco_voice_scheduler_phase_bank.sv
// Per-voice frequency word, enable and phase registers. One config write port
// and one update port; a second read port gives the table address of any voice.
module nco_phase_bank
  import nco_voice_scheduler_pkg::*;
#(
  parameter int  NUM_VOICES = NCO_NUM_VOICES,
  parameter int  FCW_W      = NCO_FCW_W,
  parameter int  LUT_AW     = NCO_LUT_AW,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we_i,
  input  logic [VW-1:0]     cfg_voice_i,
  input  logic [FCW_W-1:0]  cfg_fcw_i,
  input  logic              cfg_en_i,
  input  logic              upd_i,
  input  logic [VW-1:0]     upd_voice_i,
  output logic              upd_en_o,
  input  logic [VW-1:0]     look_voice_i,
  output logic [LUT_AW-1:0] look_addr_o
);

  logic [FCW_W-1:0]      phase_q [NUM_VOICES];
  logic [FCW_W-1:0]      fcw_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q;

  assign upd_en_o    = en_q[upd_voice_i];
  assign look_addr_o = phase_q[look_voice_i][FCW_W-1 -: LUT_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        fcw_q[i]   <= '0;
      end
      en_q <= '0;
    end else begin
      if (upd_i && en_q[upd_voice_i])
        phase_q[upd_voice_i] <= phase_q[upd_voice_i] + fcw_q[upd_voice_i];
      // A config write lands after the update: the sweep uses the old fcw/en,
      // and a disable clears the phase even if that voice advanced this cycle.
      if (cfg_we_i) begin
        fcw_q[cfg_voice_i] <= cfg_fcw_i;
        en_q[cfg_voice_i]  <= cfg_en_i;
        if (!cfg_en_i)
          phase_q[cfg_voice_i] <= '0;
      end
    end
  end

endmodule

// File: rtl/nco_voice_scheduler.sv
// Sweeps one phase-accumulate + shared sine lookup across all voices per
// next_sample tick and emits the mixed sample. NCO_SCHED_OVERRUN_EN adds a
// sticky overrun flag for ticks that arrive while a sweep is running.
module nco_voice_scheduler
  import nco_voice_scheduler_pkg::*;
#(
  parameter int  NUM_VOICES = NCO_NUM_VOICES,
  parameter int  FCW_W      = NCO_FCW_W,
  parameter int  LUT_AW     = NCO_LUT_AW,
  parameter int  SAMPLE_W   = NCO_SAMPLE_W,
  parameter int  MIX_W      = SAMPLE_W + $clog2(NUM_VOICES),
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [VW-1:0]              cfg_voice,
  input  logic [FCW_W-1:0]           cfg_fcw,
  input  logic                       cfg_en,
  input  logic                       next_sample,
  output logic [LUT_AW-1:0]          lut_addr,
  input  logic signed [SAMPLE_W-1:0] lut_data,
  output logic signed [MIX_W-1:0]    mix_out,
  output logic                       mix_valid,
  output logic                       busy,
`ifdef NCO_SCHED_OVERRUN_EN
  output logic                       overrun,
`endif
  output sched_state_t               dbg_state
);

  sched_state_t             state_q;
  logic [VW-1:0]            v_q;
  logic signed [MIX_W-1:0]  acc_q, acc_d;
  logic [LUT_AW-1:0]        lut_addr_q;
  logic signed [MIX_W-1:0]  mix_q;
  logic                     mix_valid_q;
  logic                     busy_q;
  logic                     upd;
  logic                     upd_en;
  logic [VW-1:0]            look_v;
  logic [LUT_AW-1:0]        look_addr;

  assign upd = (state_q == FETCH);
  // Outside a sweep the address tracks voice 0 so the first slot has its data ready.
  assign look_v = upd ? v_q + VW'(1) : '0;
  assign acc_d  = upd_en ? acc_q + MIX_W'(lut_data) : acc_q;

  nco_phase_bank #(
    .NUM_VOICES (NUM_VOICES),
    .FCW_W      (FCW_W),
    .LUT_AW     (LUT_AW)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .cfg_we_i     (cfg_we),
    .cfg_voice_i  (cfg_voice),
    .cfg_fcw_i    (cfg_fcw),
    .cfg_en_i     (cfg_en),
    .upd_i        (upd),
    .upd_voice_i  (v_q),
    .upd_en_o     (upd_en),
    .look_voice_i (look_v),
    .look_addr_o  (look_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= '0;
      acc_q       <= '0;
      lut_addr_q  <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      lut_addr_q  <= look_addr;
      mix_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (next_sample) begin
            state_q <= FETCH;
            v_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          acc_q <= acc_d;
          v_q   <= v_q + VW'(1);
          if (v_q == VW'(NUM_VOICES - 1))
            state_q <= DONE;
        end
        DONE: begin
          mix_q       <= acc_q;
          mix_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NCO_SCHED_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (rst)
      overrun_q <= 1'b0;
    else if (next_sample && busy_q)
      overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

  assign lut_addr  = lut_addr_q;
  assign mix_out   = mix_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Bench for nco_voice_scheduler: behavioural sweep model feeding an expected
// queue of mixed samples, plus per-slot table address and timing checks.
module tb_nco_voice_scheduler;
  import nco_voice_scheduler_pkg::*;

  localparam int NV  = 4;
  localparam int VW  = 2;
  localparam int MXW = 16;

  localparam int ACT_NONE = 0;
  localparam int ACT_CFG  = 1;
  localparam int ACT_TICK = 2;
  localparam int ACT_RST  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_we = 1'b0;
  logic [VW-1:0]       cfg_voice = '0;
  logic [23:0]         cfg_fcw = '0;
  logic                cfg_en = 1'b0;
  logic                next_sample = 1'b0;
  logic [7:0]          lut_addr;
  logic signed [13:0]  lut_data;
  logic signed [MXW-1:0] mix_out;
  logic                mix_valid;
  logic                busy;
`ifdef NCO_SCHED_OVERRUN_EN
  logic                overrun;
`endif
  sched_state_t        dbg_state;

  logic                lut_const = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  logic [31:0] exp_q[$];

  logic [23:0] m_phase [NV];
  logic [23:0] m_fcw   [NV];
  logic        m_en    [NV];

  always #5 clk = ~clk;

  nco_voice_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_fcw     (cfg_fcw),
    .cfg_en      (cfg_en),
    .next_sample (next_sample),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
`ifdef NCO_SCHED_OVERRUN_EN
    .overrun     (overrun),
`endif
    .dbg_state   (dbg_state)
  );

  function automatic logic signed [13:0] lut_tab(input logic [7:0] a);
    return 14'(int'(a) * 64 - 8192);
  endfunction

  assign lut_data = lut_const ? 14'sd8191 : lut_tab(lut_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mix_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_mix_valid", 32'd1, 32'd0);
      else check("mix_out", 32'($signed(mix_out)), exp_q.pop_front());
    end
  end

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_fcw[v]   = '0;
      m_en[v]    = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_lut_addr"}, 32'(lut_addr), 32'd0);
    check({tag, "_mix_out"}, 32'(mix_out), 32'd0);
    check({tag, "_mix_valid"}, 32'(mix_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
`ifdef NCO_SCHED_OVERRUN_EN
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    check_idle_outputs("reset");
  endtask

  task automatic cfg_write(input int v, input logic [23:0] fcw, input logic en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = VW'(v); cfg_fcw = fcw; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
    m_fcw[v] = fcw;
    m_en[v]  = en;
    if (!en) m_phase[v] = '0;
  endtask

  // One sweep; optionally a config write, extra tick or reset is driven
  // act_at cycles after the tick edge.
  task automatic sweep(input int act, input int act_at,
                       input int wv, input logic [23:0] wfcw, input logic wen);
    logic [7:0] ea [NV];
    int em, lat, bcnt, v0;
    bit got;
    em = 0;
    for (int v = 0; v < NV; v++) begin
      ea[v] = m_phase[v][23:16];
      if (m_en[v]) begin
        em += lut_const ? 8191 : int'(lut_tab(ea[v]));
        m_phase[v] = m_phase[v] + m_fcw[v];
      end
    end
    if (act != ACT_RST) exp_q.push_back(32'(em));
    v0 = valid_cnt;
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    while (lat < 12) begin
      if (busy) bcnt++;
      if (lat < NV && (act != ACT_RST || lat <= act_at))
        check($sformatf("lut_addr_v%0d", lat), 32'(lut_addr), 32'(ea[lat]));
      if (mix_valid && !got) begin
        got = 1'b1;
        check("latency", 32'(lat), 32'(NV + 1));
        check("busy_cycles", 32'(bcnt), 32'(NV + 1));
      end
      if (lat == act_at) begin
        case (act)
          ACT_CFG:  begin cfg_we = 1'b1; cfg_voice = VW'(wv); cfg_fcw = wfcw; cfg_en = wen; end
          ACT_TICK: next_sample = 1'b1;
          ACT_RST:  rst = 1'b1;
          default:  ;
        endcase
      end
      if (lat == act_at + 1) begin
        if (act == ACT_RST) begin
          check_idle_outputs("mid_rst");
          model_clear();
        end
        cfg_we = 1'b0; next_sample = 1'b0; rst = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (act == ACT_RST) begin
      check("valid_after_rst", 32'(valid_cnt - v0), 32'd0);
    end else begin
      check("valid_count", 32'(valid_cnt - v0), 32'd1);
      if (!got) check("mix_valid_seen", 32'd0, 32'd1);
    end
    if (act == ACT_CFG) begin
      m_fcw[wv] = wfcw;
      m_en[wv]  = wen;
      if (!wen) m_phase[wv] = '0;
    end
  endtask

  task automatic plain_sweep();
    sweep(ACT_NONE, -10, 0, '0, 1'b0);
  endtask

  initial begin
    model_clear();

    // Single voice stepping one table entry per sample.
    do_reset();
    cfg_write(0, 24'h010000, 1'b1);
    repeat (3) plain_sweep();

    // Full-scale sum of four voices against a constant table.
    do_reset();
    lut_const = 1'b1;
    for (int v = 0; v < NV; v++) cfg_write(v, 24'h000000, 1'b1);
    plain_sweep();
    check("full_scale_mix", 32'($signed(mix_out)), 32'd32764);

    // All voices disabled: zero mix, valid still pulses.
    for (int v = 0; v < NV; v++) cfg_write(v, 24'h000000, 1'b0);
    plain_sweep();
    lut_const = 1'b0;

    // Phase wrap on voice 1.
    do_reset();
    cfg_write(1, 24'hFFFFFF, 1'b1);
    repeat (3) plain_sweep();

    // Extra tick during a sweep is dropped.
    sweep(ACT_TICK, 1, 0, '0, 1'b0);
`ifdef NCO_SCHED_OVERRUN_EN
    check("overrun_set", 32'(overrun), 32'd1);
`endif
    plain_sweep();
`ifdef NCO_SCHED_OVERRUN_EN
    check("overrun_sticky", 32'(overrun), 32'd1);
`endif

    // Config write to an already-processed voice applies next sweep.
    do_reset();
    cfg_write(0, 24'h010000, 1'b1);
    cfg_write(2, 24'h123456, 1'b1);
    plain_sweep();
    sweep(ACT_CFG, 2, 0, 24'h020000, 1'b1);
    repeat (2) plain_sweep();

    // Reset in the voice 1 slot aborts the sweep.
    sweep(ACT_RST, 1, 0, '0, 1'b0);
    cfg_write(0, 24'h010000, 1'b1);
    plain_sweep();

    // Randomised voice configurations, including disables that clear phase.
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < NV; v++)
        if ($urandom_range(0, 1) == 1)
          cfg_write(v, 24'($urandom_range(0, 32'hFFFFFF)), 1'($urandom_range(0, 3) != 0));
      repeat (2) plain_sweep();
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
